// File: rtl/expr_lane_pipe_if.sv
// Handshake and lane bus for expr_lane_pipe: operand side (valid/ready in), result side (valid/ready out).
// The master drives operands and out_ready; the slave (the pipeline) drives results and in_ready.
interface expr_lane_pipe_if #(
  parameter int WIDTH = 6,
  parameter int LANES = 6,
  parameter int CNT_W = 16
);
  logic                     in_valid;
  logic                     in_ready;
  logic [3*LANES-1:0]       op;
  logic [LANES-1:0]         sgn;
  logic [WIDTH*LANES-1:0]   a;
  logic [WIDTH*LANES-1:0]   b;
  logic                     out_valid;
  logic                     out_ready;
  logic [WIDTH*LANES-1:0]   y;
  logic [LANES-1:0]         ovf;
  logic [CNT_W-1:0]         out_count;

  modport master (
    output in_valid, op, sgn, a, b, out_ready,
    input  in_ready, out_valid, y, ovf, out_count
  );

  modport slave (
    input  in_valid, op, sgn, a, b, out_ready,
    output in_ready, out_valid, y, ovf, out_count
  );
endinterface

// File: rtl/expr_lane_pipe.sv
// Per-lane ALU over LANES lanes in a 2-stage valid/ready pipe (2-cycle latency, 1/cycle, full backpressure).
// Optional sticky per-lane overflow record under EXPR_LANE_PIPE_STICKY_OVF_EN.
module expr_lane_pipe #(
  parameter int WIDTH = 6,
  parameter int LANES = 6,
  parameter int CNT_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  expr_lane_pipe_if.slave   bus
`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
  ,
  input  logic              sticky_clr,
  output logic [LANES-1:0]  sticky_ovf
`endif
);
  localparam int SH_W = $clog2(WIDTH);

  typedef struct packed {
    logic [WIDTH-1:0] y;
    logic             ovf;
  } lane_res_t;

  logic                    s1_valid;
  logic                    s2_valid;
  logic [3*LANES-1:0]      s1_op;
  logic [LANES-1:0]        s1_sgn;
  logic [WIDTH*LANES-1:0]  s1_a;
  logic [WIDTH*LANES-1:0]  s1_b;
  logic [WIDTH*LANES-1:0]  y_q;
  logic [WIDTH*LANES-1:0]  y_nxt;
  logic [LANES-1:0]        ovf_q;
  logic [LANES-1:0]        ovf_nxt;
  logic [CNT_W-1:0]        cnt_q;
  lane_res_t [LANES-1:0]   res;
  logic                    s2_adv;
  logic                    s1_adv;
  logic                    in_acc;
  logic                    out_hs;

  assign s2_adv       = !s2_valid || bus.out_ready;
  assign s1_adv       = s1_valid && s2_adv;
  assign bus.in_ready = !s1_valid || s1_adv;
  assign in_acc       = bus.in_valid && bus.in_ready;
  assign out_hs       = s2_valid && bus.out_ready;

  function automatic lane_res_t eval_lane(input logic [2:0] lop, input logic lsg,
                                          input logic [WIDTH-1:0] la, input logic [WIDTH-1:0] lb);
    logic [WIDTH:0]       sum;
    logic [WIDTH-1:0]     dif;
    logic [2*WIDTH-1:0]   pu;
    logic [2*WIDTH-1:0]   ps;
    logic [2*WIDTH-1:0]   shl;
    logic [SH_W-1:0]      sh;
    logic                 lt;
    lane_res_t            r;
    r   = '0;
    sum = {1'b0, la} + {1'b0, lb};
    dif = la - lb;
    pu  = {{WIDTH{1'b0}}, la} * {{WIDTH{1'b0}}, lb};
    // Low 2W bits of the sign-extended product equal the true signed product.
    ps  = {{WIDTH{la[WIDTH-1]}}, la} * {{WIDTH{lb[WIDTH-1]}}, lb};
    sh  = lb[SH_W-1:0];
    shl = {{WIDTH{1'b0}}, la} << sh;
    lt  = lsg ? ($signed(la) < $signed(lb)) : (la < lb);
    case (lop)
      3'd0: begin
        r.y   = sum[WIDTH-1:0];
        r.ovf = lsg ? ((la[WIDTH-1] == lb[WIDTH-1]) && (sum[WIDTH-1] != la[WIDTH-1])) : sum[WIDTH];
      end
      3'd1: begin
        r.y   = dif;
        r.ovf = lsg ? ((la[WIDTH-1] != lb[WIDTH-1]) && (dif[WIDTH-1] != la[WIDTH-1])) : (la < lb);
      end
      3'd2: begin
        r.y   = lsg ? ps[WIDTH-1:0] : pu[WIDTH-1:0];
        r.ovf = lsg ? !((&ps[2*WIDTH-1:WIDTH-1]) || !(|ps[2*WIDTH-1:WIDTH-1]))
                    : (|pu[2*WIDTH-1:WIDTH]);
      end
      3'd3: begin
        r.y   = shl[WIDTH-1:0];
        r.ovf = |shl[2*WIDTH-1:WIDTH];
      end
      3'd4: begin
        if ({1'b0, sh} >= (SH_W+1)'(WIDTH))
          r.y = lsg ? {WIDTH{la[WIDTH-1]}} : '0;
        else if (lsg)
          r.y = $signed(la) >>> sh;
        else
          r.y = la >> sh;
      end
      3'd5: r.y = {{(WIDTH-1){1'b0}}, lt};
      3'd6: r.y = la ~^ lb;
      3'd7: r.y = {{(WIDTH-1){1'b0}}, (la == lb)};
      default: r = '0;
    endcase
    return r;
  endfunction

  always_comb begin
    res     = '0;
    y_nxt   = '0;
    ovf_nxt = '0;
    for (int i = 0; i < LANES; i++) begin
      res[i] = eval_lane(s1_op[3*i +: 3], s1_sgn[i], s1_a[WIDTH*i +: WIDTH], s1_b[WIDTH*i +: WIDTH]);
      y_nxt[WIDTH*i +: WIDTH] = res[i].y;
      ovf_nxt[i]              = res[i].ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s1_op    <= '0;
      s1_sgn   <= '0;
      s1_a     <= '0;
      s1_b     <= '0;
      y_q      <= '0;
      ovf_q    <= '0;
      cnt_q    <= '0;
    end else begin
      if (in_acc) begin
        s1_op  <= bus.op;
        s1_sgn <= bus.sgn;
        s1_a   <= bus.a;
        s1_b   <= bus.b;
      end
      if (in_acc)
        s1_valid <= 1'b1;
      else if (s1_adv)
        s1_valid <= 1'b0;
      // s2 refills in the same cycle it drains, so no bubble on steady streaming.
      if (s2_adv)
        s2_valid <= s1_valid;
      if (s1_adv) begin
        y_q   <= y_nxt;
        ovf_q <= ovf_nxt;
      end
      if (out_hs)
        cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign bus.out_valid = s2_valid;
  assign bus.y         = y_q;
  assign bus.ovf       = ovf_q;
  assign bus.out_count = cnt_q;

`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
  logic [LANES-1:0] sticky_q;

  // A set on the handshake cycle overrides a simultaneous clear.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      sticky_q <= '0;
    else
      sticky_q <= (sticky_clr ? '0 : sticky_q) | (out_hs ? ovf_q : '0);
  end

  assign sticky_ovf = sticky_q;
`endif
endmodule

// File: tb/tb_expr_lane_pipe.sv
// Scoreboarded bench for expr_lane_pipe: directed opcode cases, latency, backpressure, reset and sticky checks.
module tb_expr_lane_pipe;
  localparam int W   = 6;
  localparam int L   = 6;
  localparam int CW  = 16;
  localparam int SHW = $clog2(W);

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  expr_lane_pipe_if #(.WIDTH(W), .LANES(L), .CNT_W(CW)) bus();

`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
  logic         sticky_clr;
  logic [L-1:0] sticky_ovf;
`endif

  expr_lane_pipe #(.WIDTH(W), .LANES(L), .CNT_W(CW)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus)
`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
    ,
    .sticky_clr (sticky_clr),
    .sticky_ovf (sticky_ovf)
`endif
  );

  typedef struct packed {
    logic [W*L-1:0] y;
    logic [L-1:0]   ovf;
  } exp_t;

  exp_t           sb[$];
  exp_t           pend;
  exp_t           mon_e;
  int             total = 0;
  int             bad   = 0;
  logic [2:0]     lop[L];
  logic           lsg[L];
  logic [W-1:0]   la[L];
  logic [W-1:0]   lb[L];
  logic [W*L-1:0] y_hold;
  logic [L-1:0]   ovf_hold;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s: got=%0h want=%0h", tag, got, want);
    end
  endtask

  // Reference by integer range arithmetic: overflow means the exact result leaves the lane's range.
  task automatic model(input logic [2:0] o, input logic s, input logic [W-1:0] av,
                       input logic [W-1:0] bv, output logic [W-1:0] ry, output logic ro);
    longint ai, bi, r, lo, hi;
    int     sh;
    ai = s ? longint'($signed(av)) : longint'(av);
    bi = s ? longint'($signed(bv)) : longint'(bv);
    lo = s ? -(longint'(1) << (W-1)) : 0;
    hi = s ? (longint'(1) << (W-1)) - 1 : (longint'(1) << W) - 1;
    sh = int'(bv[SHW-1:0]);
    r  = 0;
    ro = 1'b0;
    case (o)
      3'd0: begin r = ai + bi; ro = (r < lo) || (r > hi); end
      3'd1: begin r = ai - bi; ro = (r < lo) || (r > hi); end
      3'd2: begin r = ai * bi; ro = (r < lo) || (r > hi); end
      3'd3: begin r = longint'(av) << sh; ro = r > ((longint'(1) << W) - 1); end
      3'd4: r = ai >>> sh;
      3'd5: r = (ai < bi) ? 1 : 0;
      3'd6: r = longint'(av ~^ bv);
      default: r = (av == bv) ? 1 : 0;
    endcase
    ry = r[W-1:0];
  endtask

  task automatic rand_lanes();
    for (int i = 0; i < L; i++) begin
      lop[i] = 3'($urandom_range(0, 7));
      lsg[i] = 1'($urandom_range(0, 1));
      la[i]  = W'($urandom);
      lb[i]  = W'($urandom);
    end
  endtask

  task automatic clean_lanes();
    for (int i = 0; i < L; i++) begin
      lop[i] = 3'd6; lsg[i] = 1'b0; la[i] = W'(i); lb[i] = W'(3*i);
    end
  endtask

  // Drive the lane table onto the bus; lane 0 expectation optionally replaced by a literal.
  task automatic prep(input logic use_c, input logic [W-1:0] cy, input logic co);
    logic [W-1:0] ry;
    logic         ro;
    for (int i = 0; i < L; i++) begin
      bus.op[3*i +: 3] = lop[i];
      bus.sgn[i]       = lsg[i];
      bus.a[W*i +: W]  = la[i];
      bus.b[W*i +: W]  = lb[i];
      model(lop[i], lsg[i], la[i], lb[i], ry, ro);
      pend.y[W*i +: W] = ry;
      pend.ovf[i]      = ro;
    end
    if (use_c) begin
      pend.y[W-1:0] = cy;
      pend.ovf[0]   = co;
    end
  endtask

  task automatic handshake();
    bit done = 1'b0;
    bit hs;
    bus.in_valid = 1'b1;
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      hs = bus.in_valid && bus.in_ready;
      @(posedge clk); #2;
      if (hs) done = 1'b1;
    end
    total++;
    assert (done) else begin
      bad++;
      $error("FAIL send_timeout: got=no accept want=accept within 50 cycles");
    end
    bus.in_valid = 1'b0;
  endtask

  task automatic send_dir(input logic [2:0] o, input logic s, input logic [W-1:0] av,
                          input logic [W-1:0] bv, input logic [W-1:0] cy, input logic co);
    rand_lanes();
    lop[0] = o; lsg[0] = s; la[0] = av; lb[0] = bv;
    prep(1'b1, cy, co);
    handshake();
  endtask

  task automatic send_rand();
    rand_lanes();
    prep(1'b0, '0, 1'b0);
    handshake();
  endtask

  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #2; end
  endtask

  task automatic wait_drain();
    for (int k = 0; k < 200 && sb.size() != 0; k++) begin
      @(posedge clk); #2;
    end
    total++;
    assert (sb.size() == 0) else begin
      bad++;
      $error("FAIL drain: got=%0d pending want=0", sb.size());
    end
  endtask

  // Input presented in cycle 0, result must be visible in cycle 2.
  task automatic lat_check(input string tag, input logic use_c, input logic [W-1:0] cy,
                           input logic co, input logic [CW-1:0] cnt_after);
    prep(use_c, cy, co);
    bus.in_valid = 1'b1;
    @(negedge clk);
    chk({tag, "_in_ready"}, 64'(bus.in_ready), 64'(1));
    chk({tag, "_lat0"}, 64'(bus.out_valid), 64'(0));
    @(posedge clk); #2;
    bus.in_valid = 1'b0;
    @(negedge clk);
    chk({tag, "_lat1"}, 64'(bus.out_valid), 64'(0));
    @(negedge clk);
    chk({tag, "_lat2"}, 64'(bus.out_valid), 64'(1));
    @(posedge clk); #2;
    chk({tag, "_count"}, 64'(bus.out_count), 64'(cnt_after));
    chk({tag, "_empty"}, 64'(bus.out_valid), 64'(0));
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sb.delete();
    idle(1);
    reset = 1'b0;
    idle(1);
  endtask

  // Scoreboard: push on input handshake, pop and compare on output handshake.
  initial begin
    forever begin
      @(negedge clk);
      if (!reset) begin
        if (bus.out_valid && bus.out_ready) begin
          total++;
          assert (sb.size() != 0) else begin
            bad++;
            $error("FAIL unexpected_out: got=result y=%0h want=none", bus.y);
          end
          if (sb.size() != 0) begin
            mon_e = sb.pop_front();
            chk("y", 64'(bus.y), 64'(mon_e.y));
            chk("ovf", 64'(bus.ovf), 64'(mon_e.ovf));
          end
        end
        if (bus.in_valid && bus.in_ready)
          sb.push_back(pend);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got=timeout want=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset         = 1'b1;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    bus.op        = '0;
    bus.sgn       = '0;
    bus.a         = '0;
    bus.b         = '0;
    pend          = '0;
`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
    sticky_clr    = 1'b0;
`endif
    repeat (2) @(posedge clk);
    #2;
    chk("rst_out_valid", 64'(bus.out_valid), 64'(0));
    chk("rst_y", 64'(bus.y), 64'(0));
    chk("rst_ovf", 64'(bus.ovf), 64'(0));
    chk("rst_count", 64'(bus.out_count), 64'(0));
    reset = 1'b0;
    idle(1);
    chk("rst_in_ready", 64'(bus.in_ready), 64'(1));

    // Unsigned ADD carry-out on lane 0, with latency and first count.
    rand_lanes();
    lop[0] = 3'd0; lsg[0] = 1'b0; la[0] = 6'd60; lb[0] = 6'd5;
    lat_check("add_u", 1'b1, 6'd1, 1'b1, 16'd1);

    // Directed opcode cases streamed back to back.
    send_dir(3'd1, 1'b1, 6'd32, 6'd1, 6'd31, 1'b1);
    send_dir(3'd2, 1'b1, 6'd61, 6'd5, 6'd49, 1'b0);
    send_dir(3'd2, 1'b1, 6'd8,  6'd8, 6'd0,  1'b1);
    send_dir(3'd4, 1'b1, 6'd32, 6'd3, 6'd60, 1'b0);
    send_dir(3'd4, 1'b0, 6'd32, 6'd3, 6'd4,  1'b0);
    send_dir(3'd4, 1'b1, 6'd32, 6'd7, 6'd63, 1'b0);
    send_dir(3'd3, 1'b0, 6'd48, 6'd1, 6'd32, 1'b1);
    send_dir(3'd5, 1'b1, 6'd63, 6'd0, 6'd1,  1'b0);
    send_dir(3'd5, 1'b0, 6'd63, 6'd0, 6'd0,  1'b0);
    send_dir(3'd7, 1'b0, 6'd17, 6'd17, 6'd1, 1'b0);
    send_dir(3'd6, 1'b0, 6'd5,  6'd3,  6'd57, 1'b0);
    for (int t = 0; t < 30; t++) send_rand();
    wait_drain();
    chk("stream_count", 64'(bus.out_count), 64'(42));

    // Backpressure: two accepts fill the pipe, then outputs must hold.
    do_reset();
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    @(negedge clk);
    chk("bp_in_ready", 64'(bus.in_ready), 64'(0));
    chk("bp_out_valid", 64'(bus.out_valid), 64'(1));
    y_hold   = bus.y;
    ovf_hold = bus.ovf;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      chk("bp_y_hold", 64'(bus.y), 64'(y_hold));
      chk("bp_ovf_hold", 64'(bus.ovf), 64'(ovf_hold));
      chk("bp_stall_ready", 64'(bus.in_ready), 64'(0));
    end
    @(posedge clk); #2;
    bus.out_ready = 1'b1;
    for (int t = 0; t < 3; t++) send_rand();
    wait_drain();
    chk("bp_count", 64'(bus.out_count), 64'(5));

    // Reset with both stages full.
    bus.out_ready = 1'b0;
    send_rand();
    send_rand();
    @(negedge clk);
    chk("mid_full", 64'(bus.in_ready), 64'(0));
    @(posedge clk); #2;
    reset = 1'b1;
    #1;
    chk("mid_out_valid", 64'(bus.out_valid), 64'(0));
    chk("mid_y", 64'(bus.y), 64'(0));
    chk("mid_ovf", 64'(bus.ovf), 64'(0));
    chk("mid_count", 64'(bus.out_count), 64'(0));
    sb.delete();
    @(posedge clk); #2;
    reset = 1'b0;
    bus.out_ready = 1'b1;
    rand_lanes();
    lat_check("post_rst", 1'b0, '0, 1'b0, 16'd1);

    // Random output stalls against a random stream.
    fork
      begin
        for (int t = 0; t < 25; t++) send_rand();
      end
      begin
        repeat (60) begin
          @(posedge clk); #2;
          bus.out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    bus.out_ready = 1'b1;
    wait_drain();
    chk("rand_count", 64'(bus.out_count), 64'(26));

`ifdef EXPR_LANE_PIPE_STICKY_OVF_EN
    do_reset();
    clean_lanes();
    lop[2] = 3'd0; la[2] = 6'd60; lb[2] = 6'd5;
    prep(1'b0, '0, 1'b0);
    handshake();
    wait_drain();
    chk("sticky_set", 64'(sticky_ovf), 64'(6'b000100));
    for (int t = 0; t < 3; t++) begin
      clean_lanes();
      prep(1'b0, '0, 1'b0);
      handshake();
    end
    wait_drain();
    chk("sticky_hold", 64'(sticky_ovf), 64'(6'b000100));
    clean_lanes();
    lop[2] = 3'd0; la[2] = 6'd60; lb[2] = 6'd5;
    prep(1'b0, '0, 1'b0);
    handshake();
    @(posedge clk); #2;
    chk("sticky_ovf_present", 64'(bus.out_valid), 64'(1));
    sticky_clr = 1'b1;
    @(posedge clk); #2;
    sticky_clr = 1'b0;
    chk("sticky_set_wins", 64'(sticky_ovf), 64'(6'b000100));
    sticky_clr = 1'b1;
    @(posedge clk); #2;
    sticky_clr = 1'b0;
    chk("sticky_clr", 64'(sticky_ovf), 64'(0));
    wait_drain();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/expr_lane_pipe.md
Name: expr_lane_pipe

Overview:
- Parametrised, pipelined successor to the fixed-width combinational expression blocks.
- Evaluates LANES independent WIDTH-bit expressions per transaction; each lane has a per-lane opcode and a signed/unsigned mode.
- Transactions move through a 2-stage valid/ready pipeline with full backpressure.
- Sits between operand sources and result consumers in the regression datapath; also reports per-lane overflow and a transaction count.

Parameters:
WIDTH, 6, operand/result bit width per lane (>=2)
LANES, 6, number of independent lanes (>=1)
CNT_W, 16, width of the completed-transaction counter

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-high reset
in_valid  in  1  input transaction valid
in_ready  out  1  pipeline can accept a transaction this cycle
op  in  3*LANES  per-lane opcode, lane i = op[3i+2:3i]
sgn  in  LANES  per-lane mode: 1 = signed, 0 = unsigned
a  in  WIDTH*LANES  per-lane operand A, lane i = a[WIDTH*i +: WIDTH]
b  in  WIDTH*LANES  per-lane operand B, same packing
out_valid  out  1  result valid
out_ready  in  1  consumer accepts the result
y  out  WIDTH*LANES  per-lane results, same packing
ovf  out  LANES  per-lane overflow flag for the result currently on y
out_count  out  CNT_W  number of completed output handshakes, wraps modulo 2^CNT_W

Behaviour:
- Reset (async, active-high): s1_valid=0, s2_valid=0, out_valid=0, y=0, ovf=0, out_count=0, in_ready=1 while reset is low again.
- Stage 1 registers op/sgn/a/b on an input handshake (in_valid & in_ready).
- Stage 2 computes all lanes from the stage-1 registers and registers y/ovf; out_valid = s2_valid.
- Latency: a result appears on y 2 cycles after its input handshake when out_ready stays high. Throughput is 1 transaction per cycle.
- Handshake and backpressure:
  - s2 advances when !s2_valid | out_ready.
  - s1 advances into s2 when s1_valid & s2 advances.
  - in_ready = !s1_valid | s1 advances.
  - No combinational path from in_valid to out_valid.
  - y, ovf and out_valid hold stable while out_valid & !out_ready.
- Simultaneous output handshake and new s1 data: s2 loads the new result in the same cycle; no bubble is inserted.
- out_count increments on each out_valid & out_ready and wraps from all-ones to 0.
- Opcodes per lane (result truncated to WIDTH; sh = b[clog2(WIDTH)-1:0], unsigned):
  - 0 ADD a+b. ovf: unsigned = carry-out; signed = operands have the same sign and the result sign differs.
  - 1 SUB a-b. ovf: unsigned = a<b; signed = standard two's-complement overflow.
  - 2 MUL, low WIDTH bits of the full 2*WIDTH product. ovf: unsigned = upper WIDTH bits nonzero; signed = product bits [2W-1:W-1] not all equal.
  - 3 SHL a<<sh. ovf = any 1 shifted out.
  - 4 SHR: sgn ? a>>>sh : a>>sh. If sh>=WIDTH, result is all sign bits (signed) or 0. ovf = 0.
  - 5 LT, zero-extended 1-bit result of a<b, compared signed or unsigned per sgn. ovf = 0.
  - 6 XNOR a~^b. ovf = 0.
  - 7 EQ, zero-extended (a==b). ovf = 0.
- Lanes are fully independent; no cross-lane carries.

Optional Feature:
- Macro: EXPR_LANE_PIPE_STICKY_OVF_EN.
- When defined:
  - Adds input sticky_clr (1) and output sticky_ovf (LANES).
  - Bit i is set on every output handshake where ovf[i]=1.
  - It is cleared only by reset or by sticky_clr.
  - If sticky_clr and a set occur in the same cycle, the set wins.
- When undefined: neither port exists and there is no sticky state.

Test Plan:
- Unsigned ADD lane 0: a=60, b=5 -> y lane0=1, ovf[0]=1, out_valid 2 cycles after accept, out_count=1.
- Signed SUB a=-32 (6'b100000), b=1 -> y=31, ovf=1. Signed MUL a=-3, b=5 -> y=49 (-15), ovf=0. Signed MUL a=8, b=8 -> y=0, ovf=1.
- SHR signed a=-32, b=3 -> y=60. SHR unsigned a=32, b=3 -> y=4. SHR signed a=-32, b=7 -> y=63. SHL a=48, b=1 -> y=32, ovf=1.
- Backpressure: stream 5 transactions with out_ready low for 4 cycles.
  - in_ready drops after 2 accepts and y holds stable.
  - On release, all 5 results emerge in order with no loss or duplication, and out_count=5.
- Reset asserted mid-stream with s1 and s2 both full -> out_valid, y, ovf and out_count go to 0 immediately; the next transaction has 2-cycle latency again.
- Sticky (macro on): ADD overflow on lane 2, then 3 clean transactions -> sticky_ovf[2] stays 1. sticky_clr in the same cycle as a new lane-2 overflow -> stays 1. sticky_clr alone -> 0.
